vscale_hasti_arbiter: RTL and testbench



---
 rtl/vscale_hasti_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_vscale_hasti_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_hasti_arbiter.sv
// Two-master / one-slave HASTI (AHB-Lite) arbiter: instruction bridge (m0) and data bridge (m1) share one slave.
// Define VSCALE_HASTI_ARB_RR_EN for round-robin arbitration; default is m1 priority with an m0 starvation guard.
module vscale_hasti_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] m0_haddr,
    input  logic        m0_hwrite,
    input  logic [2:0]  m0_hsize,
    input  logic [2:0]  m0_hburst,
    input  logic        m0_hmastlock,
    input  logic [3:0]  m0_hprot,
    input  logic [1:0]  m0_htrans,
    input  logic [31:0] m0_hwdata,
    output logic [31:0] m0_hrdata,
    output logic        m0_hready,
    output logic        m0_hresp,

    input  logic [31:0] m1_haddr,
    input  logic        m1_hwrite,
    input  logic [2:0]  m1_hsize,
    input  logic [2:0]  m1_hburst,
    input  logic        m1_hmastlock,
    input  logic [3:0]  m1_hprot,
    input  logic [1:0]  m1_htrans,
    input  logic [31:0] m1_hwdata,
    output logic [31:0] m1_hrdata,
    output logic        m1_hready,
    output logic        m1_hresp,

    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic        hmastlock,
    output logic [3:0]  hprot,
    output logic [1:0]  htrans,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    // Per-master views so the address mux and ready logic index by master number
    logic [31:0] m_haddr     [2];
    logic        m_hwrite    [2];
    logic [2:0]  m_hsize     [2];
    logic [2:0]  m_hburst    [2];
    logic        m_hmastlock [2];
    logic [3:0]  m_hprot     [2];
    logic [1:0]  m_htrans    [2];
    logic [31:0] m_hwdata    [2];
    logic [1:0]  m_req;

    assign m_haddr[0]     = m0_haddr;
    assign m_haddr[1]     = m1_haddr;
    assign m_hwrite[0]    = m0_hwrite;
    assign m_hwrite[1]    = m1_hwrite;
    assign m_hsize[0]     = m0_hsize;
    assign m_hsize[1]     = m1_hsize;
    assign m_hburst[0]    = m0_hburst;
    assign m_hburst[1]    = m1_hburst;
    assign m_hmastlock[0] = m0_hmastlock;
    assign m_hmastlock[1] = m1_hmastlock;
    assign m_hprot[0]     = m0_hprot;
    assign m_hprot[1]     = m1_hprot;
    assign m_htrans[0]    = m0_htrans;
    assign m_htrans[1]    = m1_htrans;
    assign m_hwdata[0]    = m0_hwdata;
    assign m_hwdata[1]    = m1_hwdata;
    assign m_req          = {m1_htrans[1], m0_htrans[1]};

    logic        hold_q, hold_d;
    logic        hold_sel_q, hold_sel_d;
    logic        dvalid_q, dvalid_d;
    logic        downer_q, downer_d;
    logic [1:0]  rbuf_valid_q, rbuf_valid_d;
    logic [31:0] rbuf_data_q [2];
    logic [31:0] rbuf_data_d [2];
    logic [1:0]  rbuf_resp_q, rbuf_resp_d;

    logic        arb_sel;
    logic        addr_sel;
    logic        rbuf_block;
    logic        xfer;

    logic [1:0]  dphase;
    logic [1:0]  data_done;
    logic [1:0]  addr_ok;
    logic [1:0]  mready;
    logic [1:0]  capture;
    logic [31:0] m_hrdata_o [2];
    logic [1:0]  m_hresp_o;

`ifdef VSCALE_HASTI_ARB_RR_EN
    logic last_q, last_d;

    always_comb begin
        if (m_req == 2'b11) begin
            arb_sel = ~last_q;
        end else begin
            arb_sel = m_req[1];
        end
    end
`else
    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        arb_sel = m_req[1] && (!m_req[0] || (starve_cnt_q < LIMIT) || (STARVE_LIMIT == 0));
    end
`endif

    assign addr_sel = hold_q ? hold_sel_q : arb_sel;

    // A buffered response that cannot be handed over this cycle keeps its master's next
    // address off the bus, so the grant is free to move while the other data phase stalls.
    assign rbuf_block = !hold_q && rbuf_valid_q[addr_sel] && !hready;

    assign haddr     = m_haddr[addr_sel];
    assign hwrite    = m_hwrite[addr_sel];
    assign hsize     = m_hsize[addr_sel];
    assign hburst    = m_hburst[addr_sel];
    assign hmastlock = m_hmastlock[addr_sel];
    assign hprot     = m_hprot[addr_sel];
    assign htrans    = (m_req[addr_sel] && !rbuf_block) ? m_htrans[addr_sel] : HTRANS_IDLE;
    assign hwdata    = dvalid_q ? m_hwdata[downer_q] : 32'h0;

    assign xfer = hready && (htrans != HTRANS_IDLE);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign dphase[gi]    = dvalid_q && (downer_q == 1'(gi));
            assign data_done[gi] = !dphase[gi] || hready || rbuf_valid_q[gi];
            assign addr_ok[gi]   = !m_req[gi] || ((addr_sel == 1'(gi)) && hready);
            assign mready[gi]    = data_done[gi] && addr_ok[gi];
            // Data phase finished while this master is still parked in a lost address phase
            assign capture[gi]   = dphase[gi] && hready && !addr_ok[gi];

            assign rbuf_valid_d[gi] = mready[gi] ? 1'b0 : (capture[gi] ? 1'b1 : rbuf_valid_q[gi]);
            assign rbuf_data_d[gi]  = capture[gi] ? hrdata : rbuf_data_q[gi];
            assign rbuf_resp_d[gi]  = capture[gi] ? hresp : rbuf_resp_q[gi];

            assign m_hrdata_o[gi] = rbuf_valid_q[gi] ? rbuf_data_q[gi] : hrdata;
            assign m_hresp_o[gi]  = rbuf_valid_q[gi] ? rbuf_resp_q[gi] : (dphase[gi] && hresp);
        end
    endgenerate

    assign m0_hrdata = m_hrdata_o[0];
    assign m1_hrdata = m_hrdata_o[1];
    assign m0_hready = mready[0];
    assign m1_hready = mready[1];
    assign m0_hresp  = m_hresp_o[0];
    assign m1_hresp  = m_hresp_o[1];

    always_comb begin
        hold_d     = hold_q;
        hold_sel_d = hold_sel_q;
        dvalid_d   = dvalid_q;
        downer_d   = downer_q;
        if (hready) begin
            hold_d   = 1'b0;
            dvalid_d = (htrans != HTRANS_IDLE);
            downer_d = addr_sel;
        end else if (htrans != HTRANS_IDLE) begin
            hold_d     = 1'b1;
            hold_sel_d = addr_sel;
        end
    end

`ifdef VSCALE_HASTI_ARB_RR_EN
    always_comb begin
        last_d = last_q;
        if (xfer) begin
            last_d = addr_sel;
        end
    end
`else
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (xfer && !addr_sel) begin
            starve_cnt_d = '0;
        end else if (xfer && addr_sel && m_req[0] && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q         <= 1'b0;
            hold_sel_q     <= 1'b0;
            dvalid_q       <= 1'b0;
            downer_q       <= 1'b0;
            rbuf_valid_q   <= 2'b00;
            rbuf_data_q[0] <= 32'h0;
            rbuf_data_q[1] <= 32'h0;
            rbuf_resp_q    <= 2'b00;
`ifdef VSCALE_HASTI_ARB_RR_EN
            last_q         <= 1'b0;
`else
            starve_cnt_q   <= '0;
`endif
        end else begin
            hold_q         <= hold_d;
            hold_sel_q     <= hold_sel_d;
            dvalid_q       <= dvalid_d;
            downer_q       <= downer_d;
            rbuf_valid_q   <= rbuf_valid_d;
            rbuf_data_q[0] <= rbuf_data_d[0];
            rbuf_data_q[1] <= rbuf_data_d[1];
            rbuf_resp_q    <= rbuf_resp_d;
`ifdef VSCALE_HASTI_ARB_RR_EN
            last_q         <= last_d;
`else
            starve_cnt_q   <= starve_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Directed scoreboard bench for vscale_hasti_arbiter: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_vscale_hasti_arbiter;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] NS   = 2'b10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_haddr, m1_haddr;
    logic        m0_hwrite, m1_hwrite;
    logic [2:0]  m0_hsize, m1_hsize;
    logic [2:0]  m0_hburst, m1_hburst;
    logic        m0_hmastlock, m1_hmastlock;
    logic [3:0]  m0_hprot, m1_hprot;
    logic [1:0]  m0_htrans, m1_htrans;
    logic [31:0] m0_hwdata, m1_hwdata;
    logic [31:0] m0_hrdata, m1_hrdata;
    logic        m0_hready, m1_hready;
    logic        m0_hresp, m1_hresp;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    vscale_hasti_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize), .m0_hburst(m0_hburst),
        .m0_hmastlock(m0_hmastlock), .m0_hprot(m0_hprot), .m0_htrans(m0_htrans), .m0_hwdata(m0_hwdata),
        .m0_hrdata(m0_hrdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
        .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize), .m1_hburst(m1_hburst),
        .m1_hmastlock(m1_hmastlock), .m1_hprot(m1_hprot), .m1_htrans(m1_htrans), .m1_hwdata(m1_hwdata),
        .m1_hrdata(m1_hrdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
        .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock),
        .hprot(hprot), .htrans(htrans), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    always #5 clk = ~clk;

    typedef enum int {
        S_HADDR, S_HTRANS, S_HWRITE, S_HWDATA, S_M0_HREADY, S_M1_HREADY,
        S_M0_HRDATA, S_M1_HRDATA, S_M0_HRESP, S_M1_HRESP, S_HOLD, S_DVALID, S_RBUF
    } sig_e;

    typedef struct {
        int          cyc;
        sig_e        sig;
        logic [31:0] exp;
    } chk_t;

    chk_t sb_q[$];
    int   cyc_n   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] sample(sig_e s);
        case (s)
            S_HADDR:     return haddr;
            S_HTRANS:    return {30'h0, htrans};
            S_HWRITE:    return {31'h0, hwrite};
            S_HWDATA:    return hwdata;
            S_M0_HREADY: return {31'h0, m0_hready};
            S_M1_HREADY: return {31'h0, m1_hready};
            S_M0_HRDATA: return m0_hrdata;
            S_M1_HRDATA: return m1_hrdata;
            S_M0_HRESP:  return {31'h0, m0_hresp};
            S_M1_HRESP:  return {31'h0, m1_hresp};
            S_HOLD:      return {31'h0, dut.hold_q};
            S_DVALID:    return {31'h0, dut.dvalid_q};
            S_RBUF:      return {30'h0, dut.rbuf_valid_q};
            default:     return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic ex(sig_e s, logic [31:0] v);
        chk_t c;
        c.cyc = cyc_n;
        c.sig = s;
        c.exp = v;
        sb_q.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic m_set(int n, logic [31:0] a, logic w, logic [1:0] t);
        if (n == 0) begin
            m0_haddr = a; m0_hwrite = w; m0_htrans = t;
        end else begin
            m1_haddr = a; m1_hwrite = w; m1_htrans = t;
        end
    endtask

    task automatic slv(logic rdy, logic [31:0] rd, logic rsp);
        hready = rdy; hrdata = rd; hresp = rsp;
    endtask

    // Monitor: compare every expectation queued for the current cycle
    initial begin
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_n) begin
                chk_t c;
                logic [31:0] act;
                c = sb_q.pop_front();
                act = sample(c.sig);
                n_checks++;
                if (act !== c.exp) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got=%h expected=%h", c.sig.name(), c.cyc, act, c.exp);
                end else begin
                    $display("chk  %s cyc=%0d value=%h ok", c.sig.name(), c.cyc, act);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        logic m0_slot;
        reset = 1'b1;
        m0_hsize = 3'd2; m1_hsize = 3'd2; m0_hburst = 3'd0; m1_hburst = 3'd0;
        m0_hmastlock = 1'b0; m1_hmastlock = 1'b0; m0_hprot = 4'h3; m1_hprot = 4'h3;
        m0_hwdata = 32'h0; m1_hwdata = 32'h0;
        m_set(0, 32'h100, 1'b0, NS);
        m_set(1, 32'h2000, 1'b1, NS);
        slv(1'b1, 32'h0, 1'b0);
        repeat (3) step();

        // Reset release with both masters requesting; then m1 write / m0 read
        reset = 1'b0;
        ex(S_HADDR, 32'h2000); ex(S_HWRITE, 32'd1); ex(S_HTRANS, 32'd2);
        ex(S_M0_HREADY, 32'd0); ex(S_M1_HREADY, 32'd1);
        ex(S_DVALID, 32'd0); ex(S_RBUF, 32'd0); ex(S_HOLD, 32'd0);
        step();
        m_set(1, 32'h0, 1'b0, IDLE); m1_hwdata = 32'hDEADBEEF;
        ex(S_HWDATA, 32'hDEADBEEF); ex(S_HADDR, 32'h100); ex(S_HWRITE, 32'd0);
        ex(S_M0_HREADY, 32'd1); ex(S_DVALID, 32'd1);
        step();
        m_set(0, 32'h0, 1'b0, IDLE); m1_hwdata = 32'h0; slv(1'b1, 32'hCAFE0001, 1'b0);
        ex(S_M0_HRDATA, 32'hCAFE0001); ex(S_M0_HREADY, 32'd1); ex(S_HTRANS, 32'd0);
        step();
        slv(1'b1, 32'h0, 1'b0);
        step();

        // Stall during m0 address phase; m1 arrives mid-stall and loses the held grant
        m_set(1, 32'h400, 1'b0, NS);
        ex(S_HADDR, 32'h400);
        step();
        m_set(1, 32'h0, 1'b0, IDLE); m_set(0, 32'h300, 1'b0, NS); slv(1'b0, 32'h0, 1'b0);
        ex(S_HADDR, 32'h300); ex(S_HOLD, 32'd0); ex(S_M0_HREADY, 32'd0); ex(S_M1_HREADY, 32'd0);
        step();
        m_set(1, 32'h500, 1'b0, NS);
        ex(S_HADDR, 32'h300); ex(S_HOLD, 32'd1); ex(S_M0_HREADY, 32'd0); ex(S_M1_HREADY, 32'd0);
        step();
        slv(1'b1, 32'h55, 1'b0);
        ex(S_HADDR, 32'h300); ex(S_HOLD, 32'd1); ex(S_M0_HREADY, 32'd1);
        ex(S_M1_HREADY, 32'd0); ex(S_M1_HRDATA, 32'h55);
        step();
        m_set(0, 32'h0, 1'b0, IDLE); slv(1'b1, 32'h66, 1'b0);
        ex(S_RBUF, 32'd2); ex(S_HADDR, 32'h500); ex(S_HTRANS, 32'd2); ex(S_M1_HREADY, 32'd1);
        ex(S_M1_HRDATA, 32'h55); ex(S_M0_HRDATA, 32'h66); ex(S_M0_HREADY, 32'd1);
        step();
        m_set(1, 32'h0, 1'b0, IDLE); slv(1'b1, 32'h77, 1'b0);
        ex(S_M1_HRDATA, 32'h77); ex(S_M1_HREADY, 32'd1); ex(S_RBUF, 32'd0);
        step();

        // m0 read completes while m1 wins m0's next address: response buffered for m0
        m_set(0, 32'h600, 1'b0, NS); slv(1'b1, 32'h0, 1'b0);
        ex(S_HADDR, 32'h600); ex(S_M0_HREADY, 32'd1);
        step();
        m_set(0, 32'h604, 1'b0, NS); m_set(1, 32'h700, 1'b0, NS); slv(1'b1, 32'h12345678, 1'b0);
        ex(S_HADDR, 32'h700); ex(S_M0_HREADY, 32'd0); ex(S_M1_HREADY, 32'd1);
        step();
        m_set(1, 32'h0, 1'b0, IDLE); slv(1'b1, 32'hAAAA0000, 1'b0);
        ex(S_RBUF, 32'd1); ex(S_HADDR, 32'h604); ex(S_M0_HREADY, 32'd1);
        ex(S_M0_HRDATA, 32'h12345678); ex(S_M1_HRDATA, 32'hAAAA0000); ex(S_M1_HREADY, 32'd1);
        step();
        m_set(0, 32'h0, 1'b0, IDLE); slv(1'b1, 32'hBBBB0000, 1'b0);
        ex(S_RBUF, 32'd0); ex(S_M0_HRDATA, 32'hBBBB0000); ex(S_M0_HREADY, 32'd1);
        step();

        // Continuous contention: grant pattern over ten slots
        m_set(0, 32'h1000, 1'b0, NS); m_set(1, 32'h2000, 1'b0, NS); slv(1'b1, 32'h0, 1'b0);
        for (int k = 0; k < 10; k++) begin
`ifdef VSCALE_HASTI_ARB_RR_EN
            m0_slot = (k % 2) == 1;
`else
            m0_slot = (k % 5) == 4;
`endif
            ex(S_HADDR, m0_slot ? 32'h1000 : 32'h2000);
            ex(S_HTRANS, 32'd2);
            ex(S_M0_HREADY, m0_slot ? 32'd1 : 32'd0);
            step();
        end
        m_set(0, 32'h0, 1'b0, IDLE); m_set(1, 32'h0, 1'b0, IDLE);
        ex(S_HTRANS, 32'd0); ex(S_M1_HREADY, 32'd1);
        step();
        ex(S_RBUF, 32'd0);
        step();

        // Two-cycle ERROR on an m1 transfer while m0 waits
        m_set(1, 32'h800, 1'b0, NS);
        ex(S_HADDR, 32'h800);
        step();
        m_set(1, 32'h0, 1'b0, IDLE); m_set(0, 32'h900, 1'b0, NS); slv(1'b0, 32'h0, 1'b1);
        ex(S_M1_HRESP, 32'd1); ex(S_M0_HRESP, 32'd0); ex(S_M1_HREADY, 32'd0);
        ex(S_M0_HREADY, 32'd0); ex(S_HADDR, 32'h900);
        step();
        slv(1'b1, 32'h0, 1'b1);
        ex(S_M1_HRESP, 32'd1); ex(S_M0_HRESP, 32'd0); ex(S_M1_HREADY, 32'd1); ex(S_M0_HREADY, 32'd1);
        step();
        m_set(0, 32'h0, 1'b0, IDLE); slv(1'b1, 32'h0, 1'b0);
        ex(S_M0_HRESP, 32'd0); ex(S_M1_HRESP, 32'd0); ex(S_M0_HREADY, 32'd1);
        step();

        // Reset with a buffered response and a live data phase pending
        m_set(0, 32'hA00, 1'b0, NS);
        ex(S_HADDR, 32'hA00);
        step();
        m_set(0, 32'hA04, 1'b0, NS); m_set(1, 32'hB00, 1'b1, NS); slv(1'b1, 32'h99, 1'b0);
        m1_hwdata = 32'h5A5A5A5A;
        ex(S_HADDR, 32'hB00); ex(S_M0_HREADY, 32'd0);
        step();
        reset = 1'b1; m_set(0, 32'h0, 1'b0, IDLE); m_set(1, 32'h0, 1'b0, IDLE);
        ex(S_RBUF, 32'd1); ex(S_DVALID, 32'd1);
        step();
        reset = 1'b0; slv(1'b1, 32'h31, 1'b0);
        ex(S_RBUF, 32'd0); ex(S_DVALID, 32'd0); ex(S_M0_HRDATA, 32'h31);
        ex(S_M0_HREADY, 32'd1); ex(S_HWDATA, 32'h0);
        step();

        step();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
